// File: rtl/cpu_run_ctrl_pkg.sv
// ============================================================================
// Module   : cpu_run_ctrl_pkg
// Brief    : Shared state encoding and default widths for the run controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_run_ctrl_pkg;

  localparam int CPU_ADDR_W    = 5;
  localparam int CPU_DATA_W    = 16;
  localparam int CPU_MEM_DEPTH = 32;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] c_st_idle    = 3'd0;
  localparam logic [STATE_W-1:0] c_st_load    = 3'd1;
  localparam logic [STATE_W-1:0] c_st_run     = 3'd2;
  localparam logic [STATE_W-1:0] c_st_halted  = 3'd3;
  localparam logic [STATE_W-1:0] c_st_timeout = 3'd4;

endpackage

`default_nettype wire

// File: rtl/cpu_run_controller_run_watchdog.sv
// ============================================================================
// Module   : run_watchdog
// Brief    : RUN-cycle counter with optional timeout compare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module run_watchdog
  import cpu_run_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             halt,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam bit               c_wd_on = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] c_limit = c_wd_on ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [CNT_W-1:0] r_count;

  // The halting cycle is still counted, so count equals the number of RUN cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count   = r_count;
  assign expired = c_wd_on && enable && !halt && (r_count == c_limit);

endmodule

`default_nettype wire

// File: rtl/cpu_run_controller.sv
// ============================================================================
// Module   : cpu_run_controller
// Brief    : Load / run / readback sequencer owning the shared memory port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_run_controller
  import cpu_run_ctrl_pkg::*;
#(
  parameter int ADDR_W         = CPU_ADDR_W,
  parameter int DATA_W         = CPU_DATA_W,
  parameter int MEM_DEPTH      = CPU_MEM_DEPTH,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              abort,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_last,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0] core_mem_addr,
  input  logic [DATA_W-1:0] core_mem_write_data,
  input  logic              core_mem_write,
  input  logic              core_halted,
  output logic [DATA_W-1:0] core_mem_read_data,
  output logic              core_reset,
  output logic              core_start_execution,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(MEM_DEPTH - 1);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic [ADDR_W-1:0]  r_load_ptr;
  logic               r_rd_valid;
  logic [DATA_W-1:0]  r_rd_data;
  logic               w_accept;
  logic               w_load_end;
  logic               w_enter_load;
  logic               w_readback;
  logic               w_in_run;
  logic               w_wd_expired;

  assign w_accept     = (r_state == c_st_load) && host_valid;
  assign w_load_end   = w_accept && (host_last || (r_load_ptr == c_last_addr));
  assign w_enter_load = (r_state != c_st_load) && (w_next_state == c_st_load);
  assign w_readback   = (r_state == c_st_halted) || (r_state == c_st_timeout);
  assign w_in_run     = (r_state == c_st_run);

  run_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_run_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (w_enter_load),
    .enable  (w_in_run),
    .halt    (core_halted),
    .count   (cycle_count),
    .expired (w_wd_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle:    if (load_start) w_next_state = c_st_load;
        c_st_load:    if (w_load_end) w_next_state = c_st_run;
        // Halt is checked first so a simultaneous timeout loses.
        c_st_run: begin
          if (core_halted)       w_next_state = c_st_halted;
          else if (w_wd_expired) w_next_state = c_st_timeout;
        end
        c_st_halted,
        c_st_timeout: if (load_start) w_next_state = c_st_load;
        default:      w_next_state = c_st_idle;
      endcase
    end
  end

  always_comb begin
    host_ready           = 1'b0;
    core_reset           = 1'b0;
    core_start_execution = 1'b0;
    busy                 = 1'b0;
    done                 = 1'b0;
    timeout              = 1'b0;
    mem_addr             = '0;
    mem_write_data       = '0;
    mem_write            = 1'b0;
    case (r_state)
      c_st_idle: core_reset = 1'b1;
      c_st_load: begin
        core_reset     = 1'b1;
        host_ready     = 1'b1;
        busy           = 1'b1;
        mem_addr       = r_load_ptr;
        mem_write_data = host_data;
        mem_write      = host_valid;
      end
      c_st_run: begin
        core_start_execution = 1'b1;
        busy                 = 1'b1;
        mem_addr             = core_mem_addr;
        mem_write_data       = core_mem_write_data;
        mem_write            = core_mem_write;
      end
      c_st_halted: begin
        done     = 1'b1;
        mem_addr = rd_addr;
      end
      c_st_timeout: begin
        timeout  = 1'b1;
        mem_addr = rd_addr;
      end
      default: core_reset = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_load_ptr <= '0;
    end else if (w_enter_load) begin
      r_load_ptr <= '0;
    end else if (w_accept) begin
      r_load_ptr <= r_load_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_readback && rd_req;
      if (w_readback && rd_req) begin
        r_rd_data <= mem_read_data;
      end
    end
  end

  assign rd_valid           = r_rd_valid;
  assign rd_data            = r_rd_data;
  assign core_mem_read_data = mem_read_data;

endmodule

`default_nettype wire
